// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - client and server bus bundle for the four-client arbiter
interface bus_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [3:0]              rq;
  logic [3:0]              wr_ni;
  logic [4*ADDR_WIDTH-1:0] address;
  logic [4*DATA_WIDTH-1:0] dataW;
  logic [3:0]              ack;
  logic [DATA_WIDTH-1:0]   dataR;
  logic                    srv_rq;
  logic                    srv_ack;
  logic                    srv_wr_ni;
  logic [ADDR_WIDTH-1:0]   srv_address;
  logic [DATA_WIDTH-1:0]   srv_dataW;
  logic [DATA_WIDTH-1:0]   srv_dataR;
  logic [3:0]              grant;
  logic                    timeout_err;

  // Arbiter side: owns the server bus and all per-client status.
  modport master (
    input  rq, wr_ni, address, dataW, srv_ack, srv_dataR,
    output ack, dataR, srv_rq, srv_wr_ni, srv_address, srv_dataW, grant, timeout_err
  );

  // Clients and server side.
  modport slave (
    output rq, wr_ni, address, dataW, srv_ack, srv_dataR,
    input  ack, dataR, srv_rq, srv_wr_ni, srv_address, srv_dataW, grant, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter granting one of four clients a single server
module bus_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [4:0] WLAST = 5'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [4:0]            wcnt_q, wcnt_d;
  logic [3:0]            grant_q, grant_d;
  logic [1:0]            gidx_q, gidx_d;
  logic [DATA_WIDTH-1:0] dataR_q, dataR_d;
  logic                  timeout_err_q, timeout_err_d;

  logic [1:0]            pick;
  logic [1:0]            cand;
  logic                  found;

  // First requester at or after ptr, wrapping modulo four.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && bus.rq[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      wcnt_q        <= 5'd0;
      grant_q       <= 4'd0;
      gidx_q        <= 2'd0;
      dataR_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wcnt_q        <= wcnt_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      dataR_q       <= dataR_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    wcnt_d        = wcnt_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    dataR_d       = dataR_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << pick;
          gidx_d  = pick;
          wcnt_d  = 5'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A completion in the final wait cycle still counts as success.
        if (bus.srv_ack) begin
          dataR_d = bus.srv_dataR;
          state_d = RESP;
        end else if (wcnt_q == WLAST) begin
          timeout_err_d = 1'b1;
          ptr_d         = gidx_q + 2'd1;
          grant_d       = 4'd0;
          state_d       = IDLE;
        end else if (!bus.rq[gidx_q]) begin
          ptr_d   = gidx_q + 2'd1;
          grant_d = 4'd0;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      RESP: begin
        ptr_d   = gidx_q + 2'd1;
        grant_d = 4'd0;
        state_d = IDLE;
      end
      default: begin
        grant_d = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  logic                  srv_wr_ni_c;
  logic [ADDR_WIDTH-1:0] srv_address_c;
  logic [DATA_WIDTH-1:0] srv_dataW_c;

  // Idle bus presents a harmless read of address zero.
  always_comb begin
    srv_wr_ni_c   = 1'b1;
    srv_address_c = '0;
    srv_dataW_c   = '0;
    if (grant_q != 4'd0) begin
      srv_wr_ni_c   = bus.wr_ni[gidx_q];
      srv_address_c = bus.address[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
      srv_dataW_c   = bus.dataW[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.srv_wr_ni   = srv_wr_ni_c;
  assign bus.srv_address = srv_address_c;
  assign bus.srv_dataW   = srv_dataW_c;
  assign bus.srv_rq      = (state_q == REQ);
  assign bus.ack         = (state_q == RESP) ? grant_q : 4'd0;
  assign bus.grant       = grant_q;
  assign bus.dataR       = dataR_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bus_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  bus_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    int ackn;
    int seen;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.rq = 4'b0000;
    bus.wr_ni = 4'b1111;
    bus.address = 16'h0000;
    bus.dataW = 32'h0;
    bus.srv_ack = 1'b0;
    bus.srv_dataR = 8'h00;
    step();
    step();
    reset = 1'b0;

    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_srv_rq", 32'(bus.srv_rq), 32'h0);
    check("rst_dataR", 32'(bus.dataR), 32'h0);
    check("rst_wr_ni", 32'(bus.srv_wr_ni), 32'h1);
    check("rst_terr", 32'(bus.timeout_err), 32'h0);
    check("rst_addr", 32'(bus.srv_address), 32'h0);

    // Single read from client 0, acked on the second REQ cycle
    bus.rq = 4'b0001;
    bus.wr_ni = 4'b0001;
    bus.address = 16'h0003;
    step();
    check("rd_srv_rq", 32'(bus.srv_rq), 32'h1);
    check("rd_grant", 32'(bus.grant), 32'h1);
    check("rd_addr", 32'(bus.srv_address), 32'h3);
    check("rd_wr_ni", 32'(bus.srv_wr_ni), 32'h1);
    step();
    check("rd_no_ack_yet", 32'(bus.ack), 32'h0);
    bus.srv_ack = 1'b1;
    bus.srv_dataR = 8'hA5;
    step();
    check("rd_ack", 32'(bus.ack), 32'h1);
    check("rd_srv_rq_low", 32'(bus.srv_rq), 32'h0);
    check("rd_dataR", 32'(bus.dataR), 32'hA5);
    bus.srv_ack = 1'b0;
    bus.rq = 4'b0000;
    step();
    check("rd_ack_once", 32'(bus.ack), 32'h0);
    check("rd_grant_free", 32'(bus.grant), 32'h0);
    check("rd_dataR_hold", 32'(bus.dataR), 32'hA5);

    // Fairness from a fresh reset with every client requesting
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.rq = 4'b1111;
    bus.srv_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_grant%0d", i), 32'(bus.grant), 32'(4'b0001 << (i % 4)));
      step();
      check($sformatf("rr_ack%0d", i), 32'(bus.ack), 32'(4'b0001 << (i % 4)));
      step();
      check($sformatf("rr_free%0d", i), 32'(bus.ack), 32'h0);
    end
    bus.rq = 4'b0000;
    bus.srv_ack = 1'b0;
    step();

    // Write from client 2; read data is still captured on completion
    bus.rq = 4'b0100;
    bus.wr_ni = 4'b1011;
    bus.address = 16'h0200;
    bus.dataW = 32'h005C_0000;
    step();
    check("wr_grant", 32'(bus.grant), 32'h4);
    check("wr_srv_rq", 32'(bus.srv_rq), 32'h1);
    check("wr_wr_ni", 32'(bus.srv_wr_ni), 32'h0);
    check("wr_dataW", 32'(bus.srv_dataW), 32'h5C);
    check("wr_addr", 32'(bus.srv_address), 32'h2);
    bus.srv_ack = 1'b1;
    bus.srv_dataR = 8'h11;
    step();
    check("wr_ack", 32'(bus.ack), 32'h4);
    check("wr_dataR", 32'(bus.dataR), 32'h11);
    bus.srv_ack = 1'b0;
    bus.rq = 4'b0000;
    step();

    // Timeout on client 1: 16 request cycles, one error pulse, no ack
    bus.rq = 4'b0010;
    hi = 0;
    ackn = 0;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      step();
      if (bus.timeout_err) seen = 1;
      else if (bus.srv_rq) hi++;
      if (bus.ack != 4'b0000) ackn++;
    end
    check("to_seen", 32'(seen), 32'h1);
    check("to_srv_rq_cycles", 32'(hi), 32'd16);
    check("to_no_ack", 32'(ackn), 32'h0);
    bus.rq = 4'b1011;
    step();
    check("to_pulse_once", 32'(bus.timeout_err), 32'h0);
    check("to_next_grant", 32'(bus.grant), 32'h8);
    bus.srv_ack = 1'b1;
    step();
    check("to_next_ack", 32'(bus.ack), 32'h8);
    bus.srv_ack = 1'b0;
    bus.rq = 4'b0000;
    step();

    // Completion in the same cycle as the last wait cycle
    bus.rq = 4'b0001;
    bus.wr_ni = 4'b1111;
    step();
    for (int c = 0; c < 15; c++) step();
    check("col_still_req", 32'(bus.srv_rq), 32'h1);
    bus.srv_ack = 1'b1;
    bus.srv_dataR = 8'h3C;
    step();
    check("col_ack", 32'(bus.ack), 32'h1);
    check("col_terr", 32'(bus.timeout_err), 32'h0);
    check("col_dataR", 32'(bus.dataR), 32'h3C);
    bus.srv_ack = 1'b0;
    bus.rq = 4'b0000;
    step();
    check("col_terr_after", 32'(bus.timeout_err), 32'h0);

    // Reset in the middle of a transaction
    bus.rq = 4'b0010;
    bus.wr_ni = 4'b1101;
    bus.address = 16'h00A0;
    bus.dataW = 32'h0000_7700;
    step();
    check("mr_grant", 32'(bus.grant), 32'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_grant0", 32'(bus.grant), 32'h0);
    check("mr_srv_rq", 32'(bus.srv_rq), 32'h0);
    check("mr_ack", 32'(bus.ack), 32'h0);
    check("mr_addr", 32'(bus.srv_address), 32'h0);
    check("mr_dataW", 32'(bus.srv_dataW), 32'h0);
    check("mr_wr_ni", 32'(bus.srv_wr_ni), 32'h1);
    check("mr_dataR", 32'(bus.dataR), 32'h0);
    check("mr_terr", 32'(bus.timeout_err), 32'h0);
    bus.rq = 4'b1001;
    step();
    check("mr_first_grant", 32'(bus.grant), 32'h1);

    // Client 0 abandons its request while waiting
    bus.srv_dataR = 8'hFF;
    step();
    bus.rq = 4'b1000;
    step();
    check("ab_grant", 32'(bus.grant), 32'h0);
    check("ab_ack", 32'(bus.ack), 32'h0);
    check("ab_dataR", 32'(bus.dataR), 32'h0);
    check("ab_terr", 32'(bus.timeout_err), 32'h0);
    step();
    check("ab_next_grant", 32'(bus.grant), 32'h8);

    bus.rq = 4'b0000;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
